// File: rtl/multiplier_division_pipe_if.sv
// Handshake and data bundle for multiplier_division_pipe; slave is the block,
// master is whoever drives it.
interface multiplier_division_pipe_if #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned LANES     = 4,
   parameter int unsigned LEN_W     = 8
);
   logic                         i_recip_valid;
   logic [BIT_WIDTH-1:0]         i_recip;
   logic [LEN_W-1:0]             i_vec_len;
   logic                         i_valid;
   logic                         o_ready;
   logic [LANES*BIT_WIDTH-1:0]   i_dataA;
   logic                         o_valid;
   logic                         i_ready;
   logic [LANES*BIT_WIDTH-1:0]   o_data;
   logic                         o_last;
   logic                         o_busy;
   logic                         o_sat;

   modport slave (
      input  i_recip_valid, i_recip, i_vec_len, i_valid, i_dataA, i_ready,
      output o_ready, o_valid, o_data, o_last, o_busy, o_sat
   );

   modport master (
      output i_recip_valid, i_recip, i_vec_len, i_valid, i_dataA, i_ready,
      input  o_ready, o_valid, o_data, o_last, o_busy, o_sat
   );
endinterface

// File: rtl/multiplier_division_pipe.sv
// Per-lane divide-by-reciprocal: clamp negatives, multiply, round and saturate
// through a 2-stage elastic pipeline, framed into vectors of i_vec_len beats.
module multiplier_division_pipe #(
   parameter int unsigned BIT_WIDTH = 16,
   parameter int unsigned FRAC_A    = 12,
   parameter int unsigned FRAC_B    = 16,
   parameter int unsigned FRAC_O    = 16,
   parameter int unsigned LANES     = 4,
   parameter int unsigned LEN_W     = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   multiplier_division_pipe_if.slave io
);
   localparam int unsigned Shift = FRAC_A + FRAC_B - FRAC_O;
   localparam int unsigned PW    = 2 * BIT_WIDTH;
   localparam logic [PW:0] RoundHalf = {{PW{1'b0}}, 1'b1} << (Shift - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e                     r_state;
   logic [BIT_WIDTH-1:0]       r_recip;
   logic [LEN_W-1:0]           r_len;
   logic [LEN_W-1:0]           r_cnt;

   logic                       r_s1_valid;
   logic                       r_s1_last;
   logic [PW-1:0]              r_s1_prod [LANES];
   logic                       r_s2_valid;
   logic                       r_s2_last;
   logic [LANES*BIT_WIDTH-1:0] r_s2_data;
   logic                       r_sat;

   logic                       w_s1_adv;
   logic                       w_s2_adv;
   logic                       w_accept;
   logic                       w_load;
   logic                       w_last_beat;
   logic [PW-1:0]              w_prod [LANES];
   logic [PW:0]                w_rnd [LANES];
   logic [LANES*BIT_WIDTH-1:0] w_res;
   logic [LANES-1:0]           w_lane_sat;

   // A stage may take new data when its downstream is empty or draining this cycle.
   assign w_s2_adv    = !r_s2_valid || io.i_ready;
   assign w_s1_adv    = !r_s1_valid || w_s2_adv;
   assign io.o_ready  = (r_state == StRun) && w_s1_adv;
   assign w_accept    = io.i_valid && io.o_ready;
   assign w_load      = (r_state == StIdle) && io.i_recip_valid;
   assign w_last_beat = (r_cnt == (r_len - LEN_W'(1)));

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         if (io.i_dataA[k*BIT_WIDTH + BIT_WIDTH - 1]) begin
            w_prod[k] = '0;
         end else begin
            w_prod[k] = PW'(io.i_dataA[k*BIT_WIDTH +: BIT_WIDTH]) * PW'(r_recip);
         end
      end
   end

   always_comb begin
      w_res      = '0;
      w_lane_sat = '0;
      w_rnd      = '{default: '0};
      for (int k = 0; k < LANES; k++) begin
         w_rnd[k] = ({1'b0, r_s1_prod[k]} + RoundHalf) >> Shift;
         if (|w_rnd[k][PW:BIT_WIDTH]) begin
            w_lane_sat[k]                   = 1'b1;
            w_res[k*BIT_WIDTH +: BIT_WIDTH] = '1;
         end else begin
            w_res[k*BIT_WIDTH +: BIT_WIDTH] = w_rnd[k][BIT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
         r_recip <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (io.i_recip_valid) begin
                  r_recip <= io.i_recip;
                  r_len   <= io.i_vec_len;
                  r_cnt   <= '0;
                  r_state <= StRun;
               end
            end
            StRun: begin
               if (w_accept) begin
                  if (w_last_beat) begin
                     r_cnt   <= '0;
                     r_state <= StDrain;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            StDrain: begin
               if (!r_s1_valid && !r_s2_valid) begin
                  r_state <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s2_last  <= 1'b0;
         r_s2_data  <= '0;
         r_sat      <= 1'b0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            r_s1_last  <= w_accept && w_last_beat;
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_valid && r_s1_last;
            if (r_s1_valid) begin
               r_s2_data <= w_res;
            end
         end
         if (w_load) begin
            r_sat <= 1'b0;
         end else if (w_s2_adv && r_s1_valid && |w_lane_sat) begin
            r_sat <= 1'b1;
         end
      end
   end

   // Products are qualified by r_s1_valid, so they need no reset.
   always_ff @(posedge i_clk) begin
      if (w_s1_adv && w_accept) begin
         r_s1_prod <= w_prod;
      end
   end

   assign io.o_valid = r_s2_valid;
   assign io.o_data  = r_s2_data;
   assign io.o_last  = r_s2_last;
   assign io.o_busy  = (r_state != StIdle);
   assign io.o_sat   = r_sat;
endmodule

// File: tb/tb_multiplier_division_pipe.sv
// Self-checking bench: directed corner cases plus randomized vectors scored
// against an arithmetic reference model.
module tb_multiplier_division_pipe;
   localparam int unsigned BW    = 16;
   localparam int unsigned FA    = 12;
   localparam int unsigned FB    = 16;
   localparam int unsigned FO    = 16;
   localparam int unsigned LN    = 4;
   localparam int unsigned LW    = 3;
   localparam int unsigned DW    = BW * LN;
   localparam int          Shift = FA + FB - FO;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   multiplier_division_pipe_if #(.BIT_WIDTH(BW), .LANES(LN), .LEN_W(LW)) bus ();

   multiplier_division_pipe #(
      .BIT_WIDTH(BW), .FRAC_A(FA), .FRAC_B(FB), .FRAC_O(FO), .LANES(LN), .LEN_W(LW)
   ) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required $finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: negative lanes clamp to 0, real-valued a*r rescaled with round-half-up.
   function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] a, input logic [BW-1:0] r,
                                              output bit sat);
      logic [DW-1:0] res;
      logic [BW-1:0] lane;
      longint        av;
      longint        q;
      res = '0;
      sat = 1'b0;
      for (int k = 0; k < LN; k++) begin
         lane = a[k*BW +: BW];
         av   = ($signed(lane) < 0) ? 64'sd0 : longint'(lane);
         q    = (av * longint'(r) + (longint'(1) << (Shift - 1))) / (longint'(1) << Shift);
         if (q > (longint'(1) << BW) - 1) begin
            q   = (longint'(1) << BW) - 1;
            sat = 1'b1;
         end
         res[k*BW +: BW] = q[BW-1:0];
      end
      return res;
   endfunction

   function automatic logic [DW-1:0] rand_beat();
      logic [DW-1:0] v;
      logic [BW-1:0] l;
      v = '0;
      for (int k = 0; k < LN; k++) begin
         case ($urandom_range(0, 3))
            0:       l = {1'b1, (BW-1)'($urandom)};
            1:       l = BW'($urandom_range(0, 255));
            2:       l = BW'($urandom);
            default: l = {1'b0, {(BW-1){1'b1}}};
         endcase
         v[k*BW +: BW] = l;
      end
      return v;
   endfunction

   task automatic idle_inputs();
      bus.i_recip_valid = 1'b0;
      bus.i_recip       = '0;
      bus.i_vec_len     = '0;
      bus.i_valid       = 1'b0;
      bus.i_dataA       = '0;
      bus.i_ready       = 1'b0;
   endtask

   task automatic load(input logic [BW-1:0] r, input logic [LW-1:0] len);
      @(negedge clk);
      bus.i_recip_valid = 1'b1;
      bus.i_recip       = r;
      bus.i_vec_len     = len;
      bus.i_valid       = 1'b0;
      @(negedge clk);
      bus.i_recip_valid = 1'b0;
      #1;
      check_eq("load_busy", bus.o_busy, 1);
      check_eq("load_sat_clr", bus.o_sat, 0);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.o_busy && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq(tag, bus.o_busy, 0);
   endtask

   // One beat, vector of length 1, no backpressure: output appears two cycles later.
   task automatic send_one(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] exp);
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_ready = 1'b1;
      bus.i_dataA = a;
      #1;
      check_eq({tag, "_ready"}, bus.o_ready, 1);
      @(negedge clk);
      bus.i_valid = 1'b0;
      #1;
      check_eq({tag, "_lat1_valid"}, bus.o_valid, 0);
      @(negedge clk);
      #1;
      check_eq({tag, "_valid"}, bus.o_valid, 1);
      check_eq({tag, "_data"}, bus.o_data, exp);
      check_eq({tag, "_last"}, bus.o_last, 1);
      @(negedge clk);
      #1;
      check_eq({tag, "_after_valid"}, bus.o_valid, 0);
      wait_idle({tag, "_idle"});
   endtask

   task automatic run_vector(input string tag, input int n, input int low_pct, input bit inject,
                             input logic [BW-1:0] r);
      logic [DW-1:0] exp_q [$];
      bit            last_q [$];
      int            issued = 0;
      int            cyc = 0;
      bit            exp_sat = 1'b0;
      bit            s;
      bit            prev_stall = 1'b0;
      logic [DW-1:0] prev_data = '0;
      logic          prev_last = 1'b0;
      logic [DW-1:0] a;
      load(r, LW'(n));
      while (!(issued == n && exp_q.size() == 0 && !bus.o_busy) && cyc < 600) begin
         @(negedge clk);
         cyc++;
         a                 = rand_beat();
         bus.i_dataA       = a;
         bus.i_valid       = (low_pct == 0) ? 1'b1 : ($urandom_range(0, 99) < 80);
         bus.i_ready       = ($urandom_range(0, 99) >= low_pct);
         bus.i_recip_valid = inject && (issued == 2);
         bus.i_recip       = r ^ 16'h5555;
         bus.i_vec_len     = LW'(n + 1);
         #1;
         if (prev_stall) begin
            check_eq({tag, "_hold_valid"}, bus.o_valid, 1);
            check_eq({tag, "_hold_data"}, bus.o_data, prev_data);
            check_eq({tag, "_hold_last"}, bus.o_last, prev_last);
         end
         if (issued == n) begin
            check_eq({tag, "_ready_drain"}, bus.o_ready, 0);
         end else if (low_pct == 0) begin
            check_eq({tag, "_nobubble"}, bus.o_ready, 1);
         end
         if (bus.i_valid && bus.o_ready && issued < n) begin
            exp_q.push_back(ref_beat(a, r, s));
            last_q.push_back(issued + 1 == n);
            exp_sat = exp_sat | s;
            issued++;
         end
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
               check_eq({tag, "_extra_out"}, bus.o_valid, 0);
            end else begin
               check_eq({tag, "_data"}, bus.o_data, exp_q.pop_front());
               check_eq({tag, "_last"}, bus.o_last, last_q.pop_front());
            end
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_data  = bus.o_data;
         prev_last  = bus.o_last;
      end
      bus.i_valid       = 1'b0;
      bus.i_recip_valid = 1'b0;
      check_eq({tag, "_in_budget"}, cyc < 600, 1);
      check_eq({tag, "_issued"}, issued, n);
      check_eq({tag, "_sat"}, bus.o_sat, exp_sat);
      check_eq({tag, "_idle"}, bus.o_busy, 0);
   endtask

   initial begin
      logic [DW-1:0] a;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check_eq("rst_valid", bus.o_valid, 0);
      check_eq("rst_ready", bus.o_ready, 0);
      check_eq("rst_last", bus.o_last, 0);
      check_eq("rst_busy", bus.o_busy, 0);
      check_eq("rst_sat", bus.o_sat, 0);
      check_eq("rst_data", bus.o_data, 0);
      rst_n = 1'b1;

      // Basic multiply: 1.0 * 0.5
      load(16'h8000, 3'd1);
      send_one("basic", 64'h0000_0000_0000_1000, 64'h0000_0000_0000_8000);
      check_eq("basic_sat", bus.o_sat, 0);

      // Negative clamp and saturation, sticky until the next load
      load(16'hFFFF, 3'd1);
      send_one("clampsat", 64'h0000_0000_7FFF_8000, 64'h0000_0000_FFFF_0000);
      check_eq("sat_set", bus.o_sat, 1);
      repeat (5) @(negedge clk);
      #1;
      check_eq("sat_sticky", bus.o_sat, 1);

      // Rounding at the half-LSB boundary
      load(16'h0800, 3'd1);
      send_one("round_up", 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001);
      load(16'h07FF, 3'd1);
      send_one("round_dn", 64'h0001_0001_0001_0001, 64'h0000_0000_0000_0000);

      // Backpressure with 30% i_ready low, length 8
      run_vector("bp8", 8, 30, 1'b0, 16'h9A3C);
      // Length field 0 means 8; back-to-back with a reciprocal load attempted in RUN
      run_vector("wrap", 8, 0, 1'b1, 16'h2468);
      run_vector("rnd5", 5, 50, 1'b0, BW'($urandom));
      run_vector("rnd3", 3, 10, 1'b1, BW'($urandom));

      // Reset mid-vector after 3 of 5 beats
      load(16'h4000, 3'd5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.i_valid = 1'b1;
         bus.i_ready = 1'b1;
         bus.i_dataA = rand_beat();
         #1;
         check_eq("mid_ready", bus.o_ready, 1);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      check_eq("mrst_valid", bus.o_valid, 0);
      check_eq("mrst_busy", bus.o_busy, 0);
      check_eq("mrst_ready", bus.o_ready, 0);
      check_eq("mrst_data", bus.o_data, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.i_valid = 1'b1;
         #1;
         check_eq("post_rst_valid", bus.o_valid, 0);
         check_eq("post_rst_ready", bus.o_ready, 0);
      end
      bus.i_valid = 1'b0;
      a = 64'h0000_2000_0000_1000;
      load(16'h4000, 3'd1);
      send_one("recover", a, 64'h0000_8000_0000_4000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multiplier_division_pipe.md
MULTIPLIER_DIVISION_PIPE -- requirements
Module: multiplier_division_pipe

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning the per-lane width of A, B and the output.
REQ-002 SHALL have parameter FRAC_A, default 12, meaning the fractional bits of A (signed Q4.12).
REQ-003 SHALL have parameter FRAC_B, default 16, meaning the fractional bits of the reciprocal (unsigned Q0.16).
REQ-004 SHALL have parameter FRAC_O, default 16, meaning the fractional bits of the output (unsigned Q0.16); the value SHALL satisfy FRAC_O < FRAC_A+FRAC_B.
REQ-005 SHALL have parameter LANES, default 4, meaning the parallel elements per beat.
REQ-006 SHALL have parameter LEN_W, default 8, meaning the width of the vector-length field.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock.
REQ-008 SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port i_recip_valid, input, 1 bit: loads i_recip and i_vec_len; it is honoured only in IDLE.
REQ-010 SHALL have port i_recip, input, BIT_WIDTH bits: unsigned reciprocal, Q0.FRAC_B.
REQ-011 SHALL have port i_vec_len, input, LEN_W bits: beats per vector, where 0 means 2^LEN_W.
REQ-012 SHALL have port i_valid, input, 1 bit: the A beat is valid.
REQ-013 SHALL have port o_ready, output, 1 bit: the block accepts an A beat.
REQ-014 SHALL have port i_dataA, input, LANES*BIT_WIDTH bits: signed Q.FRAC_A values, lane k at bits [k*BIT_WIDTH +: BIT_WIDTH].
REQ-015 SHALL have port o_valid, output, 1 bit: an output beat is valid.
REQ-016 SHALL have port i_ready, input, 1 bit: downstream accepts the output beat.
REQ-017 SHALL have port o_data, output, LANES*BIT_WIDTH bits: unsigned Q0.FRAC_O results, using the same lane packing as i_dataA.
REQ-018 SHALL have port o_last, output, 1 bit: marks the final beat of a vector.
REQ-019 SHALL have port o_busy, output, 1 bit: the block is not IDLE.
REQ-020 SHALL have port o_sat, output, 1 bit: sticky flag, set when any lane saturated since the last reciprocal load.

Function
REQ-021 SHALL implement FSM states IDLE, RUN and DRAIN.
- IDLE -> RUN on i_recip_valid.
- RUN -> DRAIN when the last beat of the vector is accepted.
- DRAIN -> IDLE when the pipeline is empty and no output is pending.
REQ-022 SHALL, on i_recip_valid in IDLE, latch the reciprocal and the length, clear the beat counter and clear o_sat.
REQ-023 SHALL drive o_ready = (state==RUN) && stage-1 can advance; a beat is accepted when i_valid && o_ready.
REQ-024 SHALL ignore i_recip_valid in RUN and DRAIN, leaving the latched reciprocal unchanged.
REQ-025 SHALL implement a 2-stage pipeline.
- S1: clamp each lane and multiply it by the latched reciprocal into a 2*BIT_WIDTH unsigned product.
- S2: round, saturate and register the result.
REQ-026 SHALL clamp any lane with A < 0 (signed) to 0 before the multiply.
REQ-027 SHALL compute the shift as FRAC_A+FRAC_B-FRAC_O.
REQ-028 SHALL compute each result as (prod + 2^(shift-1)) >> shift, evaluated without overflow (at least 2*BIT_WIDTH+1 bits).
REQ-029 SHALL force a lane to all-ones and set o_sat when that lane's rounded result exceeds 2^BIT_WIDTH-1.
REQ-030 SHALL hold latency at exactly 2 cycles from acceptance to o_valid when no stall occurs, giving a throughput of 1 beat per cycle.
REQ-031 SHALL advance a pipeline stage when its downstream stage is empty or being consumed; with o_valid=1 and i_ready=0, o_data, o_last and o_valid SHALL hold stable.
REQ-032 SHALL never drop or duplicate a beat under any i_ready pattern.
REQ-033 SHALL count accepted beats; the beat that brings the count to the length SHALL carry o_last=1 through the pipeline, and the counter SHALL wrap to 0.
REQ-034 SHALL, when an output is consumed in the same cycle a new beat is accepted, perform both without bubbles.
REQ-035 SHALL drive o_busy = (state != IDLE).

Reset
REQ-036 SHALL, on i_rst_n=0 at a rising i_clk, set state=IDLE and clear all pipeline valids, the counter and o_sat.
REQ-037 SHALL drive the outputs to the following reset values:
- o_valid=0, o_ready=0, o_last=0, o_busy=0, o_sat=0
- o_data=0
REQ-038 SHALL, on reset mid-vector or mid-DRAIN, discard in-flight beats, emit no output afterwards, and require a new reciprocal load before accepting data.

Verification
REQ-039 SHALL verify basic multiply: recip=0x8000, len=1, lane0 A=0x1000 -> 2 cycles later o_data lane0=0x8000, o_last=1, o_sat=0.
REQ-040 SHALL verify negative clamp and saturation: A lanes {0x8000, 0x7FFF}, recip=0xFFFF -> lane0=0x0000, lane1=0xFFFF, o_sat=1 and sticky until the next load.
REQ-041 SHALL verify rounding: recip=0x0800, A=0x0001 -> 0x0001; recip=0x07FF, A=0x0001 -> 0x0000.
REQ-042 SHALL verify backpressure: len=8, random i_ready with 30% low -> 8 beats out in order, output held stable while stalled, o_last only on beat 8, FSM returns to IDLE.
REQ-043 SHALL verify back-to-back operation and length wrap: len=0 with LEN_W=3 -> 8 beats, o_last on the 8th; i_recip_valid during RUN is ignored and results use the original recip.
REQ-044 SHALL verify reset mid-vector: assert i_rst_n=0 after 3 of 5 beats -> o_valid=0 the next cycle, o_busy=0, no further outputs, o_ready=0 until the next reciprocal load.
